// File: rtl/uart_rx_if.sv
// Byte-side port bundle of the UART receiver: single-entry valid/ready output plus sticky status.
interface uart_rx_if;
  logic [7:0] dout;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  // Handshake: dout transfers on a rising clk edge where rx_valid && rx_ready; once raised,
  // rx_valid holds and dout stays stable until that transfer (an overrun may replace dout).
  modport master (output dout, output rx_valid, output frame_err, output overrun, input rx_ready);
  modport slave  (input dout, input rx_valid, input frame_err, input overrun, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx_p, times bit centres from the start-bit falling edge,
// and presents each byte through a single-entry valid/ready register with sticky error flags.
module uart_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_p,
  uart_rx_if.master  bus,
  output logic [1:0] dbg_state
);
  localparam int CYCLE = CLK_FRE * 1_000_000 / BAUD_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam int CW    = $clog2(CYCLE) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic            rx_m, rx_s, rx_d;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            data_smp, stop_smp;
  logic            fall;
  logic [7:0]      dout_q;
  logic            valid_q, ferr_q, ovr_q;

  assign fall      = rx_d & ~rx_s;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_p;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    data_smp = 1'b0;
    stop_smp = 1'b0;
    case (state)
      IDLE:  if (fall) state_n = START;
      // A start bit that is high again at its centre was only a glitch.
      START: if (cnt == HALF_LAST) state_n = rx_s ? IDLE : DATA;
      DATA: begin
        if (cnt == CYC_LAST) begin
          data_smp = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CYC_LAST) begin
          stop_smp = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (state_n != state || data_smp) cnt <= '0;
      else if (state != IDLE)           cnt <= cnt + CW'(1);
      if (state == START && state_n == DATA) bit_idx <= 3'd0;
      else if (data_smp)                     bit_idx <= bit_idx + 3'd1;
      if (data_smp) shift <= {rx_s, shift[7:1]};
    end
  end

  // Later assignments win: a completing byte overrides a same-cycle accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (valid_q && bus.rx_ready) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (stop_smp && rx_s) begin
        dout_q  <= shift;
        valid_q <= 1'b1;
        ferr_q  <= 1'b0;
        if (valid_q && !bus.rx_ready) ovr_q <= 1'b1;
      end
      if (stop_smp && !rx_s) ferr_q <= 1'b1;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the bus UART transmitter. Same frame format: 8N1, LSB first, idle-high line.
- Oversamples the asynchronous serial input on the system clock, locates each bit centre from the start-bit falling edge and assembles a byte.
- Hands each byte to the bus side through a single-entry valid/ready output register.
- Flags framing errors and overruns.

Parameters:
- CLK_FRE, 50, system clock frequency in MHz.
- BAUD_RATE, 115200, serial baud rate.
- Derived localparams:
  - CYCLE = CLK_FRE*1_000_000/BAUD_RATE (integer division; 434 at defaults).
  - HALF = CYCLE/2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous reset, active-high.
- rx_p  input  1  serial data input, asynchronous to clk, idle high.
- dout  output  8  received byte, stable while rx_valid=1.
- rx_valid  output  1  byte available in dout.
- rx_ready  input  1  consumer accepts dout when rx_valid&&rx_ready.
- frame_err  output  1  sticky: last frame had stop bit = 0.
- overrun  output  1  sticky: a byte completed while the previous byte was unconsumed.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; synchronizer flops = 1; bit counter 0; shift register 0; clock counter 0.
  - dout = 8'h00; rx_valid = 0; frame_err = 0; overrun = 0.
  - Reset mid-frame discards the partial byte. After release, the receiver needs a fresh falling edge.
- Input path:
  - rx_p passes through a 2-flop synchronizer (rx_s).
  - An edge register holds rx_s from the previous cycle (rx_d).
  - Falling edge = rx_d==1 && rx_s==0.
- Clock counter:
  - Width $clog2(CYCLE)+1.
  - Cleared on every state transition.
  - Otherwise increments each cycle; no free-run between frames.
- States:
  - IDLE: on falling edge, go to START with counter=0. A line held low never retriggers (edge required).
  - START: when counter==HALF-1, sample rx_s.
    - If 0: go to DATA, bit index=0, counter=0.
    - If 1: glitch; return to IDLE with no flags changed.
  - DATA: when counter==CYCLE-1, sample rx_s, reset the counter and shift the sample into the byte LSB-first (shift right, sample into bit 7).
    - After the 8th sample (index 7), go to STOP.
    - Samples therefore fall at bit centres.
  - STOP: when counter==CYCLE-1, sample rx_s, then go to IDLE.
    - Sample 1: valid frame. Next cycle: dout=byte, rx_valid=1, frame_err=0.
    - Sample 0: frame_err=1; dout and rx_valid unchanged; byte dropped.
- Latency: rx_valid rises on the clock edge following the stop-bit sample. The stop-bit sample is about 9.5 bit periods after the synchronized falling edge.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1, then clears on the next edge.
  - dout must not change while rx_valid=1, except when an overrun overwrites it.
- Overrun (valid byte completes while rx_valid=1 and rx_ready=0):
  - dout takes the new byte; rx_valid stays 1; overrun=1.
  - overrun clears on the next accepted handshake.
- Simultaneous accept and completion (rx_ready=1 in the cycle the new byte loads):
  - The completion wins: rx_valid stays 1 with the new byte.
  - overrun is not set.
- frame_err clears only on the next valid frame or on reset. Its state does not affect rx_valid or the handshake.
- Back-to-back frames:
  - IDLE is re-entered after the stop-bit centre.
  - The next start edge is accepted immediately.
  - No idle time between frames is required.
- Any unreachable state encoding returns to IDLE.

Test Plan:
- Bench parameters for all scenarios: CLK_FRE=50, BAUD_RATE=5_000_000, so CYCLE=10 and HALF=5.
- 8N1 frame 0x55 at 10 clk/bit, rx_ready=0 -> rx_valid=1 and dout=0x55 about 97 cycles after the falling edge; frame_err=0 and overrun=0. Then pulse rx_ready for one cycle -> rx_valid=0 on the next cycle.
- Low pulse of 3 cycles on an idle line -> return to IDLE; rx_valid, frame_err and overrun stay 0. A following 0xA3 frame is received correctly.
- Frame 0xA3 with stop bit driven 0 -> frame_err=1, rx_valid stays 0. Next good frame 0x3C -> dout=0x3C, rx_valid=1, frame_err=0.
- Frames 0x12 then 0x34 back-to-back with rx_ready=0 -> after the second: dout=0x34, rx_valid=1, overrun=1. Pulse rx_ready -> rx_valid=0 and overrun=0.
- rx_ready held 1 over frames 0xFF, 0x00, 0x81 -> each byte is presented with rx_valid for exactly 1 cycle, in order; no flags set.
- Assert rst midway through the data bits of 0x5A, release, then send 0xC3 -> outputs are at reset values during rst; no 0x5A byte appears; 0xC3 is received correctly.
